// File: rtl/cpu_comb_pkg.sv
// cpu_comb shared types: opcode encoding and datapath width.
// Consumed by cpu_comb_alu and cpu_comb.
package cpu_comb_pkg;

  localparam int DW = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_XCHG = 4'd8,
    OP_MOVC = 4'd9,
    OP_MOVD = 4'd10,
    OP_SHL  = 4'd11,
    OP_SHR  = 4'd12,
    OP_RLC  = 4'd13,
    OP_INC  = 4'd14,
    OP_DEC  = 4'd15
  } op_e;

endpackage

// File: rtl/cpu_comb_alu.sv
// cpu_comb_alu: combinational next-state function of the
// accumulator CPU register file and carry flag.
module cpu_comb_alu
  import cpu_comb_pkg::*;
(
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  input  logic [DW-1:0] d_i,
  input  logic          carry_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [DW-1:0] c_o,
  output logic [DW-1:0] d_o,
  output logic          carry_o
);

  // Nine-bit scratch: bit DW is carry-out or borrow.
  logic [DW:0] sum;

  always_comb begin
    a_o     = a_i;
    b_o     = b_i;
    c_o     = c_i;
    d_o     = d_i;
    carry_o = carry_i;
    sum     = '0;
    unique case (op_e'(op_i))
      OP_NOP: begin
      end
      OP_ADD: begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        a_o     = sum[DW-1:0];
        carry_o = sum[DW];
      end
      OP_SUB: begin
        sum     = {1'b0, a_i} - {1'b0, b_i};
        a_o     = sum[DW-1:0];
        carry_o = sum[DW];
      end
      OP_ADC: begin
        sum     = {1'b0, a_i} + {1'b0, b_i}
                + {{DW{1'b0}}, carry_i};
        a_o     = sum[DW-1:0];
        carry_o = sum[DW];
      end
      OP_AND: begin
        a_o     = a_i & b_i;
        carry_o = 1'b0;
      end
      OP_OR: begin
        a_o     = a_i | b_i;
        carry_o = 1'b0;
      end
      OP_XOR: begin
        a_o     = a_i ^ b_i;
        carry_o = 1'b0;
      end
      OP_NOT: begin
        a_o     = ~a_i;
        carry_o = 1'b0;
      end
      OP_XCHG: begin
        a_o = b_i;
        b_o = a_i;
      end
      OP_MOVC: c_o = a_i;
      OP_MOVD: d_o = a_i;
      OP_SHL: begin
        a_o     = {a_i[DW-2:0], 1'b0};
        carry_o = a_i[DW-1];
      end
      OP_SHR: begin
        a_o     = {1'b0, a_i[DW-1:1]};
        carry_o = a_i[0];
      end
      OP_RLC: begin
        a_o     = {a_i[DW-2:0], carry_i};
        carry_o = a_i[DW-1];
      end
      OP_INC: begin
        sum     = {1'b0, a_i} + (DW+1)'(1);
        a_o     = sum[DW-1:0];
        carry_o = sum[DW];
      end
      OP_DEC: begin
        sum     = {1'b0, a_i} - (DW+1)'(1);
        a_o     = sum[DW-1:0];
        carry_o = sum[DW];
      end
    endcase
  end

endmodule

// File: rtl/cpu_comb.sv
// cpu_comb: registered execution stage of the 8-bit accumulator CPU.
// Define CPU_COMB_ZFLAG_EN to add the registered Zout zero flag.
module cpu_comb
  import cpu_comb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    op,
  input  logic [DW-1:0] Ain,
  input  logic [DW-1:0] Bin,
  input  logic [DW-1:0] Cin,
  input  logic [DW-1:0] Din,
  input  logic          Carryin,
  output logic [DW-1:0] Aout,
  output logic [DW-1:0] Bout,
  output logic [DW-1:0] Cout,
  output logic [DW-1:0] Dout,
  output logic          Carryout
`ifdef CPU_COMB_ZFLAG_EN
  ,
  output logic          Zout
`endif
);

  logic [DW-1:0] a_d, b_d, c_d, d_d;
  logic [DW-1:0] a_q, b_q, c_q, d_q;
  logic          carry_d, carry_q;

  cpu_comb_alu u_alu (
    .op_i    (op),
    .a_i     (Ain),
    .b_i     (Bin),
    .c_i     (Cin),
    .d_i     (Din),
    .carry_i (Carryin),
    .a_o     (a_d),
    .b_o     (b_d),
    .c_o     (c_d),
    .d_o     (d_d),
    .carry_o (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      carry_q <= carry_d;
    end
  end

  assign Aout     = a_q;
  assign Bout     = b_q;
  assign Cout     = c_q;
  assign Dout     = d_q;
  assign Carryout = carry_q;

`ifdef CPU_COMB_ZFLAG_EN
  logic z_d, z_q;

  // Flag follows whichever register the op writes.
  always_comb begin
    z_d = (a_d == '0);
    unique case (op_e'(op))
      OP_NOP:  z_d = z_q;
      OP_MOVC: z_d = (c_d == '0);
      OP_MOVD: z_d = (d_d == '0);
      default: z_d = (a_d == '0);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= 1'b0;
    else        z_q <= z_d;
  end

  assign Zout = z_q;
`endif

endmodule

// File: tb/tb_cpu_comb.sv
// Self-checking bench for cpu_comb: directed vector table,
// reset sequences and random ops against an arithmetic model.
module tb_cpu_comb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] op;
  logic [7:0] Ain, Bin, Cin, Din;
  logic       Carryin;
  logic [7:0] Aout, Bout, Cout, Dout;
  logic       Carryout;
`ifdef CPU_COMB_ZFLAG_EN
  logic       Zout;
`endif

  int checks   = 0;
  int failures = 0;
  logic exp_z  = 1'b0;

  cpu_comb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .Ain      (Ain),
    .Bin      (Bin),
    .Cin      (Cin),
    .Din      (Din),
    .Carryin  (Carryin),
    .Aout     (Aout),
    .Bout     (Bout),
    .Cout     (Cout),
    .Dout     (Dout),
    .Carryout (Carryout)
`ifdef CPU_COMB_ZFLAG_EN
    ,
    .Zout     (Zout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, c, d;
    logic       ci;
    logic [7:0] ea, eb, ec, ed;
    logic       eco;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int o, int a, int b, int ci,
                              int ea, int eco);
    vec_t v;
    v.op = 4'(o);  v.a = 8'(a); v.b = 8'(b);
    v.c = 8'h0F;   v.d = 8'hF0; v.ci = 1'(ci);
    v.ea = 8'(ea); v.eb = v.b;  v.ec = v.c; v.ed = v.d;
    v.eco = 1'(eco);
    return v;
  endfunction

  // Reference model from the op definitions, using integer arithmetic.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int a = v.a, b = v.b, ci = v.ci, s;
    r.ea = v.a; r.eb = v.b; r.ec = v.c; r.ed = v.d; r.eco = v.ci;
    case (int'(v.op))
      1:  begin s = a + b;      r.ea = 8'(s % 256); r.eco = s > 255; end
      2:  begin r.ea = 8'((a - b + 256) % 256); r.eco = a < b; end
      3:  begin s = a + b + ci; r.ea = 8'(s % 256); r.eco = s > 255; end
      4:  begin r.ea = v.a & v.b; r.eco = 0; end
      5:  begin r.ea = v.a | v.b; r.eco = 0; end
      6:  begin r.ea = v.a ^ v.b; r.eco = 0; end
      7:  begin r.ea = 8'(255 - a); r.eco = 0; end
      8:  begin r.ea = v.b; r.eb = v.a; end
      9:  r.ec = v.a;
      10: r.ed = v.a;
      11: begin r.ea = 8'((a * 2) % 256); r.eco = a >= 128; end
      12: begin r.ea = 8'(a / 2); r.eco = 1'(a % 2); end
      13: begin r.ea = 8'((a * 2) % 256 + ci); r.eco = a >= 128; end
      14: begin r.ea = 8'((a + 1) % 256); r.eco = a == 255; end
      15: begin r.ea = 8'((a + 255) % 256); r.eco = a == 0; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive(vec_t v);
    op = v.op; Ain = v.a; Bin = v.b; Cin = v.c; Din = v.d;
    Carryin = v.ci;
  endtask

  task automatic check_out(vec_t v, string tag, bit use_tbl);
    vec_t m = model(v);
    if (v.op == 4'd9)       exp_z = (m.ec == 0);
    else if (v.op == 4'd10) exp_z = (m.ed == 0);
    else if (v.op != 4'd0)  exp_z = (m.ea == 0);
    if (use_tbl) begin
      chk({tag, ".A"}, Aout, v.ea);
      chk({tag, ".B"}, Bout, v.eb);
      chk({tag, ".C"}, Cout, v.ec);
      chk({tag, ".D"}, Dout, v.ed);
      chk({tag, ".carry"}, Carryout, v.eco);
    end else begin
      chk({tag, ".A"}, Aout, m.ea);
      chk({tag, ".B"}, Bout, m.eb);
      chk({tag, ".C"}, Cout, m.ec);
      chk({tag, ".D"}, Dout, m.ed);
      chk({tag, ".carry"}, Carryout, m.eco);
    end
`ifdef CPU_COMB_ZFLAG_EN
    chk({tag, ".Z"}, Zout, exp_z);
`endif
  endtask

  task automatic run(vec_t v, string tag, bit use_tbl);
    drive(v);
    @(posedge clk);
    #1;
    check_out(v, tag, use_tbl);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".A"}, Aout, 0);
    chk({tag, ".B"}, Bout, 0);
    chk({tag, ".C"}, Cout, 0);
    chk({tag, ".D"}, Dout, 0);
    chk({tag, ".carry"}, Carryout, 0);
`ifdef CPU_COMB_ZFLAG_EN
    chk({tag, ".Z"}, Zout, 0);
`endif
  endtask

  initial begin
    vec_t v;
    tbl.push_back(mk(0,  8'hCC, 8'h55, 1, 8'hCC, 1));
    tbl.push_back(mk(1,  8'hCC, 8'h55, 1, 8'h21, 1));
    tbl.push_back(mk(2,  8'hCC, 8'h55, 1, 8'h77, 0));
    tbl.push_back(mk(3,  8'hCC, 8'h55, 1, 8'h22, 1));
    tbl.push_back(mk(4,  8'hCC, 8'h55, 1, 8'h44, 0));
    tbl.push_back(mk(5,  8'hCC, 8'h55, 1, 8'hDD, 0));
    tbl.push_back(mk(6,  8'hCC, 8'h55, 1, 8'h99, 0));
    tbl.push_back(mk(7,  8'hCC, 8'h55, 1, 8'h33, 0));
    v = mk(8, 8'hCC, 8'h55, 1, 8'h55, 1); v.eb = 8'hCC;
    tbl.push_back(v);
    v = mk(9, 8'hCC, 8'h55, 1, 8'hCC, 1); v.ec = 8'hCC;
    tbl.push_back(v);
    v = mk(10, 8'hCC, 8'h55, 1, 8'hCC, 1); v.ed = 8'hCC;
    tbl.push_back(v);
    tbl.push_back(mk(11, 8'hCC, 8'h55, 1, 8'h98, 1));
    tbl.push_back(mk(12, 8'hCC, 8'h55, 1, 8'h66, 0));
    tbl.push_back(mk(13, 8'hCC, 8'h55, 1, 8'h99, 1));
    tbl.push_back(mk(14, 8'h01, 8'h55, 1, 8'h02, 0));
    tbl.push_back(mk(15, 8'h02, 8'h55, 1, 8'h01, 0));
    tbl.push_back(mk(14, 8'hFF, 8'h55, 0, 8'h00, 1));
    tbl.push_back(mk(15, 8'h00, 8'h55, 0, 8'hFF, 1));
    tbl.push_back(mk(1,  8'h0A, 8'h06, 1, 8'h10, 0));
    tbl.push_back(mk(2,  8'h0A, 8'h06, 1, 8'h04, 0));
    tbl.push_back(mk(3,  8'h0A, 8'h06, 1, 8'h11, 0));
    tbl.push_back(mk(2,  8'h06, 8'h0A, 0, 8'hFC, 1));
    tbl.push_back(mk(6,  8'h5A, 8'h5A, 1, 8'h00, 0));
    tbl.push_back(mk(0,  8'h12, 8'h34, 0, 8'h12, 0));

    // Reset state
    rst_n = 1'b0;
    drive(mk(1, 8'hCC, 8'h55, 1, 0, 0));
    @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    foreach (tbl[i])
      run(tbl[i], $sformatf("vec%0d_op%0d", i, tbl[i].op), 1'b1);

    // Async reset assertion between edges after a nonzero result
    run(mk(1, 8'hCC, 8'h55, 1, 8'h21, 1), "pre_rst", 1'b1);
    #2;
    rst_n = 1'b0;
    exp_z = 1'b0;
    #1;
    chk_zero("async_rst");
    drive(mk(5, 8'h0F, 8'hA0, 1, 8'hAF, 0));
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out(mk(5, 8'h0F, 8'hA0, 1, 8'hAF, 0), "rst_release", 1'b1);

    // Mid-sequence reset: pending result never appears
    drive(mk(14, 8'h41, 8'h00, 0, 8'h42, 0));
    #3;
    rst_n = 1'b0;
    exp_z = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("mid_rst");
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      v.op = 4'($urandom_range(0, 15));
      v.a  = 8'($urandom); v.b = 8'($urandom);
      v.c  = 8'($urandom); v.d = 8'($urandom);
      v.ci = 1'($urandom);
      if ($urandom_range(0, 9) == 0) v.a = 8'h00;
      if ($urandom_range(0, 9) == 0) v.a = 8'hFF;
      if ($urandom_range(0, 9) == 0) v.b = v.a;
      run(v, $sformatf("rnd%0d_op%0d", i, v.op), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_comb.md
# cpu_comb

Execution stage of the team's 8-bit accumulator CPU. It takes the current register file (A, B, C, D) and the carry flag, applies one of 16 operations selected by a 4-bit opcode, and presents the next register-file state and carry. Results are registered, so it drops between instruction decode and the architectural register file.

## Interface
- No parameters; data width is fixed at 8 bits and opcode width at 4 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- op  input  4  opcode
- Ain, Bin, Cin, Din  input  8 each  current register values
- Carryin  input  1  current carry flag
- Aout, Bout, Cout, Dout  output  8 each  next register values (registered)
- Carryout  output  1  next carry flag (registered)
- Zout  output  1  zero flag; present only with the configuration macro

## Operation
- Registers not written by an op pass through unchanged, including carry unless stated otherwise.
- The ops are:
  - 0 NOP: all pass through.
  - 1 ADD: A=A+B; carry=bit 8 of the sum; Carryin ignored.
  - 2 SUB: A=A-B; carry=borrow, i.e. 1 when A<B unsigned.
  - 3 ADC: A=A+B+Carryin; carry=bit 8.
  - 4 AND: A=A&B; carry=0.
  - 5 OR: A=A|B; carry=0.
  - 6 XOR: A=A^B; carry=0.
  - 7 NOT: A=~A; carry=0.
  - 8 XCHG: A and B swapped.
  - 9 MOVC: C=A.
  - 10 MOVD: D=A.
  - 11 SHL: A={A[6:0],0}; carry=A[7].
  - 12 SHR: A={0,A[7:1]}; carry=A[0].
  - 13 RLC: A={A[6:0],Carryin}; carry=A[7].
  - 14 INC: A=A+1; carry=1 only on FF->00.
  - 15 DEC: A=A-1; carry=1 only on 00->FF.
- All arithmetic is modulo 256 and unsigned.
- The next-state logic is purely combinational; there are no undefined opcodes.

## Timing
- Outputs register on the rising edge of clk, with 1-cycle latency from op and inputs to outputs.
- rst_n low drives all outputs to 0 immediately, independent of clk. This includes Carryout and Zout.
- When rst_n deasserts, the first rising edge with rst_n high loads the computed result.
- Reset asserted mid-sequence discards the pending result. There is no partial update.
- Inputs may change every cycle. Each edge samples only the inputs present at that edge; there is no handshake.

## Configuration
- CPU_COMB_ZFLAG_EN defined: adds the Zout port, registered with the other outputs.
  - Zout=1 when the register written by the op (A for ops 1-7 and 11-15, A for 8, C for 9, D for 10) is 00 after the op.
  - For NOP, Zout holds its previous value.
- Macro not defined: no Zout port and no flag logic. All other behaviour is identical.

## Structure
- Package cpu_comb_pkg holds:
  - the opcode enum (OP_NOP…OP_DEC, values 0-15);
  - the data-width constant (8).
- Sub-module cpu_comb_alu is pure combinational: it maps op, the four registers and carry to next-state values.
- The top module instantiates cpu_comb_alu and adds the async-reset output registers and the optional zero flag.

## Test plan
- Common setup: A=CC, B=55, C=0F, D=F0, Carryin=1. Step op 0..13, one per cycle; all unlisted registers hold their input values.
  - op 0 gives A=CC.
  - op 1 gives A=21, carry=1.
  - op 2 gives A=77, carry=0.
  - op 3 gives A=22, carry=1.
- Logic and moves from the same setup:
  - op 4/5/6/7 give A=44/DD/99/33, carry=0.
  - op 8 gives A=55, B=CC.
  - op 9 gives C=CC.
  - op 10 gives D=CC.
- Shifts from the same setup:
  - op 11 gives A=98, carry=1.
  - op 12 gives A=66, carry=0.
  - op 13 gives A=99, carry=1.
- Increment/decrement:
  - op 14 with A=01 gives 02, carry=0.
  - op 15 with A=02 gives 01, carry=0.
  - op 14 with A=FF gives 00, carry=1.
  - op 15 with A=00 gives FF, carry=1.
- Small arithmetic with A=0A, B=06, Carryin=1:
  - op 1 gives A=10, carry=0.
  - op 2 gives A=04, carry=0.
  - op 3 gives A=11, carry=0.
  - op 2 with A=06, B=0A gives A=FC, carry=1.
- Reset:
  - Assert rst_n between clock edges after a nonzero result: all outputs go to 0 with no clock edge.
  - Deassert rst_n: the first rising edge loads the pending result.
  - With CPU_COMB_ZFLAG_EN: op 6 with A=B=5A gives Zout=1.
